// File: rtl/sqd.sv
// Byte-stream sequence detector for AA AA FF CF with a one-cycle registered detection pulse
// and a registered accept strobe.
module sqd (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       data_valid_in,
   input  logic [7:0] data_in,
   output logic       detected_out,
   output logic       data_valid_out
);

   localparam logic [7:0] ByteA = 8'hAA;
   localparam logic [7:0] ByteF = 8'hFF;
   localparam logic [7:0] ByteC = 8'hCF;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StS1   = 2'd1,
      StS2   = 2'd2,
      StS3   = 2'd3
   } state_e;

   state_e state_q, state_d;
   logic   detected_q, detected_d;
   logic   data_valid_q, data_valid_d;
   logic   accept;

   assign accept = enable & data_valid_in;

   always_comb begin
      state_d      = state_q;
      detected_d   = 1'b0;
      data_valid_d = accept;
      if (accept) begin
         unique case (state_q)
            StIdle: state_d = (data_in == ByteA) ? StS1 : StIdle;
            StS1:   state_d = (data_in == ByteA) ? StS2 : StIdle;
            StS2: begin
               if (data_in == ByteF) begin
                  state_d = StS3;
               end else if (data_in == ByteA) begin
                  state_d = StS2;
               end else begin
                  state_d = StIdle;
               end
            end
            StS3: begin
               // A terminating CF never seeds a new match; only AA restarts one.
               if (data_in == ByteC) begin
                  state_d    = StIdle;
                  detected_d = 1'b1;
               end else if (data_in == ByteA) begin
                  state_d = StS1;
               end else begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         detected_q   <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         detected_q   <= detected_d;
         data_valid_q <= data_valid_d;
      end
   end

   assign detected_out   = detected_q;
   assign data_valid_out = data_valid_q;

endmodule

// File: tb/tb_sqd.sv
// Directed self-checking bench for sqd; expected outputs are hand-derived per step.
module tb_sqd;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       data_valid_in;
   logic [7:0] data_in;
   logic       detected_out;
   logic       data_valid_out;

   int tests;
   int fails;

   sqd dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .data_valid_in  (data_valid_in),
      .data_in        (data_in),
      .detected_out   (detected_out),
      .data_valid_out (data_valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic det_exp, input logic dv_exp);
      tests++;
      assert (detected_out === det_exp && data_valid_out === dv_exp)
      else begin
         fails++;
         $error("FAIL %s: observed det=%b dv=%b expected det=%b dv=%b",
                tag, detected_out, data_valid_out, det_exp, dv_exp);
      end
   endtask

   // Apply one cycle of inputs, then check outputs 1 time unit after the edge.
   task automatic step(input string tag, input logic en, input logic v, input logic [7:0] d,
                       input logic det_exp, input logic dv_exp);
      enable        = en;
      data_valid_in = v;
      data_in       = d;
      @(posedge clk);
      #1;
      check(tag, det_exp, dv_exp);
   endtask

   initial begin
      tests         = 0;
      fails         = 0;
      reset         = 1'b1;
      enable        = 1'b0;
      data_valid_in = 1'b0;
      data_in       = 8'h00;
      #1;
      check("reset_async", 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_held", 1'b0, 1'b0);
      reset = 1'b0;

      // Zeros: no detection, strobe follows accept
      for (int i = 0; i < 4; i++) step("zeros", 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);

      // Invalid cycle inside a match is ignored
      step("gap_aa1", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("gap_aa2", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("gap_ff",  1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      step("gap_inv", 1'b1, 1'b0, 8'hCF, 1'b0, 1'b0);
      step("gap_cf",  1'b1, 1'b1, 8'hCF, 1'b1, 1'b1);
      step("gap_one", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

      // Leading noise then a full sequence
      step("noise_cf", 1'b1, 1'b1, 8'hCF, 1'b0, 1'b1);
      step("noise_ef", 1'b1, 1'b1, 8'hEF, 1'b0, 1'b1);
      step("noise_ff", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      step("noise_aa1", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("noise_aa2", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("noise_ff2", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      step("noise_cf2", 1'b1, 1'b1, 8'hCF, 1'b1, 1'b1);

      // Reset mid-sequence discards the partial match
      step("rst_aa1", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("rst_aa2", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("rst_ff",  1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      reset   = 1'b1;
      data_in = 8'hCF;
      #1;
      check("rst_async_mid", 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("rst_cycle", 1'b0, 1'b0);
      reset = 1'b0;
      step("rst_cf",  1'b1, 1'b1, 8'hCF, 1'b0, 1'b1);
      step("rst_aa3", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("rst_aa4", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("rst_ff2", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      step("rst_cf2", 1'b1, 1'b1, 8'hCF, 1'b1, 1'b1);

      // Overlap in S2
      step("ovl_aa1", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("ovl_aa2", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("ovl_aa3", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("ovl_ff",  1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      step("ovl_cf",  1'b1, 1'b1, 8'hCF, 1'b1, 1'b1);

      // Wrong byte in S3 breaks the match
      step("brk_aa1", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("brk_aa2", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("brk_ff",  1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      step("brk_ef",  1'b1, 1'b1, 8'hEF, 1'b0, 1'b1);
      step("brk_cf",  1'b1, 1'b1, 8'hCF, 1'b0, 1'b1);

      // Disabled cycles hold state and zero both outputs
      step("dis_aa1", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("dis_aa2", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("dis_ff",  1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      step("dis_off1", 1'b0, 1'b1, 8'hCF, 1'b0, 1'b0);
      step("dis_off2", 1'b0, 1'b1, 8'hCF, 1'b0, 1'b0);
      step("dis_cf",  1'b1, 1'b1, 8'hCF, 1'b1, 1'b1);

      // Back-to-back sequences, then AA in S3 restarting a match
      step("b2b_aa1", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("b2b_aa2", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("b2b_ff",  1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      step("b2b_cf",  1'b1, 1'b1, 8'hCF, 1'b1, 1'b1);
      step("b2b_aa3", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("b2b_aa4", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("b2b_ff2", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      step("b2b_aa5", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("b2b_aa6", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
      step("b2b_ff3", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
      step("b2b_cf2", 1'b1, 1'b1, 8'hCF, 1'b1, 1'b1);
      step("b2b_tail", 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sqd.md
SQD -- requirements
Module: sqd

Interface
REQ-001 Parameters: none; the detected sequence SHALL be fixed at 8'hAA, 8'hAA, 8'hFF, 8'hCF, in arrival order.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  block enable; when low, no byte is accepted.
REQ-005 data_valid_in  input  1  qualifies data_in for the current cycle.
REQ-006 data_in  input  8  byte stream under inspection.
REQ-007 detected_out  output  1  one-cycle pulse marking completion of the sequence.
REQ-008 data_valid_out  output  1  registered copy of the accepted-byte strobe.

Function
REQ-009 A byte SHALL be accepted on a rising clk edge only when enable=1 and data_valid_in=1; non-accepted cycles SHALL be ignored and SHALL NOT break a partial match.
REQ-010 The FSM SHALL have four states: IDLE (0 bytes matched), S1 (AA), S2 (AA AA) and S3 (AA AA FF), encoded in 2 bits.
REQ-011 IDLE on an accepted byte: AA SHALL go to S1; any other byte SHALL go to IDLE.
REQ-012 S1 on an accepted byte: AA SHALL go to S2; any other byte SHALL go to IDLE.
REQ-013 S2 on an accepted byte: FF SHALL go to S3; AA SHALL stay in S2 (overlap); any other byte SHALL go to IDLE.
REQ-014 S3 on an accepted byte: CF SHALL go to IDLE and assert detection; AA SHALL go to S1; any other byte SHALL go to IDLE.
REQ-015 On a cycle with no accepted byte, the state SHALL hold.
REQ-016 detected_out SHALL be registered and SHALL be 1 for exactly the one cycle following the edge that accepts the terminating CF in S3 (latency 1 clock); otherwise it SHALL be 0.
REQ-017 data_valid_out SHALL be registered as (enable AND data_valid_in), with latency 1 clock.
REQ-018 Back-to-back sequences SHALL each pulse detected_out; a CF does not seed a new match.
REQ-019 While enable=0, the state SHALL hold and both outputs SHALL be 0 on the following cycle.

Reset
REQ-020 reset=1 SHALL immediately (asynchronously) force the state to IDLE, detected_out=0 and data_valid_out=0, independent of clk.
REQ-021 Reset asserted mid-sequence SHALL discard the partial match; bytes received before the reset SHALL NOT contribute to a later detection.
REQ-022 After reset deasserts, the first accepted byte SHALL be evaluated from IDLE on the next rising edge.

Verification
REQ-023 Reset held 3 cycles, then enable=1, valid=1, bytes 00 x4 -> detected_out=0 throughout; data_valid_out=1 from 1 cycle after enable.
REQ-024 Bytes AA, AA, FF, one cycle with valid=0 (data CF), then valid CF -> the invalid cycle is ignored; detected_out pulses 1 cycle after the valid CF; data_valid_out=0 for 1 cycle following the gap.
REQ-025 Bytes CF, EF, FF, AA, AA, FF, CF -> exactly one detected_out pulse, 1 cycle after the final CF.
REQ-026 Bytes AA, AA, FF, then reset=1 for 1 cycle (data CF), then CF, AA, AA, FF, CF -> no pulse for the CF after reset; one pulse after the final CF.
REQ-027 Bytes AA, AA, AA, FF, CF -> one pulse (overlap in S2); AA, AA, FF, EF, CF -> no pulse.
REQ-028 Bytes AA, AA, FF with enable=0 for 2 cycles, then enable=1 with CF -> state held; detected_out pulses after the CF, and is 0 during and immediately after the disabled cycles.
